// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch conditions, M ops,
// multiply/divide FSM states and forwarding selects.
package exec_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Operand signedness per M op; magnitudes are iterated, sign fixed at the end.
  function automatic logic mdSignedA(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic mdSignedB(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/execute_stage_muldiv.sv
// Iterative M-extension unit: shift-add multiply and restoring divide, one
// bit per cycle on operand magnitudes, with sign and corner-case fix-up.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        opQ;
  logic [XLEN-1:0]   aQ, bQ, opB;
  logic [2*XLEN-1:0] acc, accNext;

  logic [XLEN-1:0]   aMag, bMag, mAdd;
  logic [XLEN:0]     mSum, dPart, dDiff;

  assign aMag = (mdSignedA(op) && a[XLEN-1]) ? -a : a;
  assign bMag = (mdSignedB(op) && b[XLEN-1]) ? -b : b;

  // Multiply: acc = {partial hi, multiplier}, add then shift right.
  // Divide:   acc = {remainder, dividend/quotient}, shift left, trial subtract.
  assign mAdd  = acc[0] ? opB : {XLEN{1'b0}};
  assign mSum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mAdd};
  assign dPart = acc[2*XLEN-1:XLEN-1];
  assign dDiff = dPart - {1'b0, opB};

  always_comb begin
    if (opQ[2])
      accNext = {(dDiff[XLEN] ? dPart[XLEN-1:0] : dDiff[XLEN-1:0]),
                 acc[XLEN-2:0], ~dDiff[XLEN]};
    else
      accNext = {mSum, acc[XLEN-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      opQ   <= '0;
      aQ    <= '0;
      bQ    <= '0;
      opB   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start && !flush) begin
          state <= ST_RUN;
          cnt   <= CW'(XLEN);
          opQ   <= op;
          aQ    <= a;
          bQ    <= b;
          opB   <= bMag;
          acc   <= {{XLEN{1'b0}}, aMag};
        end
        ST_RUN: if (flush) begin
          state <= ST_IDLE;
        end else begin
          acc <= accNext;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = ((state == ST_IDLE) && start && !flush) || (state == ST_RUN);
  assign done = (state == ST_DONE);

  logic              negP, bZero, ovf;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  assign negP  = (mdSignedA(opQ) && aQ[XLEN-1]) ^ (mdSignedB(opQ) && bQ[XLEN-1]);
  assign prod  = negP ? -acc : acc;
  assign quo   = acc[XLEN-1:0];
  assign rem   = acc[2*XLEN-1:XLEN];
  assign bZero = (bQ == '0);
  assign ovf   = mdSignedB(opQ) && (aQ == {1'b1, {(XLEN-1){1'b0}}}) && (&bQ);

  always_comb begin
    case (opQ)
      MD_MUL:  result = prod[XLEN-1:0];
      MD_DIV:  result = bZero ? '1 : ovf ? aQ :
                        (aQ[XLEN-1] ^ bQ[XLEN-1]) ? -quo : quo;
      MD_DIVU: result = bZero ? '1 : quo;
      MD_REM:  result = bZero ? aQ : ovf ? '0 : aQ[XLEN-1] ? -rem : rem;
      MD_REMU: result = bZero ? aQ : rem;
      default: result = prod[2*XLEN-1:XLEN];
    endcase
  end

endmodule

// File: rtl/execute_stage_m.sv
// RV32 execute stage with forwarding, extended ALU, branch/JALR resolution,
// an optional iterative multiply/divide unit and the EX/MEM register.
module execute_stage_m
  import exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int MULDIV_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic              JalrE,
  input  logic              ALUSrcE,
  input  logic              MulDivE,
  input  logic [1:0]        ResultSrcE,
  input  logic [3:0]        ALUControlE,
  input  logic [2:0]        BranchTypeE,
  input  logic [2:0]        MulDivOpE,
  input  logic [XLEN-1:0]   RD1E,
  input  logic [XLEN-1:0]   RD2E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   ImmExtE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [REG_AW-1:0] RDE,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [1:0]        Forward_AE,
  input  logic [1:0]        Forward_BE,
  input  logic              FlushE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              PCSrcE,
  output logic              BusyE,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [REG_AW-1:0] RDM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] srcA, srcBF, srcB, aluRes, jalrSum;
  logic [SW-1:0]   shamt;

  always_comb begin
    case (Forward_AE)
      FWD_WB:  srcA = ResultW;
      FWD_MEM: srcA = ALUResultM;
      default: srcA = RD1E;
    endcase
    case (Forward_BE)
      FWD_WB:  srcBF = ResultW;
      FWD_MEM: srcBF = ALUResultM;
      default: srcBF = RD2E;
    endcase
  end

  assign srcB  = ALUSrcE ? ImmExtE : srcBF;
  assign shamt = srcB[SW-1:0];

  always_comb begin
    case (ALUControlE)
      ALU_ADD:  aluRes = srcA + srcB;
      ALU_SUB:  aluRes = srcA - srcB;
      ALU_AND:  aluRes = srcA & srcB;
      ALU_OR:   aluRes = srcA | srcB;
      ALU_XOR:  aluRes = srcA ^ srcB;
      ALU_SLT:  aluRes = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      ALU_SLTU: aluRes = {{(XLEN-1){1'b0}}, srcA < srcB};
      ALU_SLL:  aluRes = srcA << shamt;
      ALU_SRL:  aluRes = srcA >> shamt;
      ALU_SRA:  aluRes = $unsigned($signed(srcA) >>> shamt);
      default:  aluRes = '0;
    endcase
  end

  // Branches compare against the forwarded rs2, never the immediate.
  logic brEq, brLt, brLtu, brCond;
  assign brEq  = (srcA == srcBF);
  assign brLt  = $signed(srcA) < $signed(srcBF);
  assign brLtu = srcA < srcBF;

  always_comb begin
    case (BranchTypeE)
      BR_BEQ:  brCond = brEq;
      BR_BNE:  brCond = !brEq;
      BR_BLT:  brCond = brLt;
      BR_BGE:  brCond = !brLt;
      BR_BLTU: brCond = brLtu;
      BR_BGEU: brCond = !brLtu;
      default: brCond = 1'b0;
    endcase
  end

  assign jalrSum   = srcA + ImmExtE;
  assign PCTargetE = JalrE ? {jalrSum[XLEN-1:1], 1'b0} : PCE + ImmExtE;
  assign PCSrcE    = !FlushE && ((BranchE && brCond) || JumpE);

  logic            mdBusy, mdDone;
  logic [XLEN-1:0] mdResult;

  generate
    if (MULDIV_EN != 0) begin : g_md
      muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (MulDivE),
        .op     (MulDivOpE),
        .a      (srcA),
        .b      (srcBF),
        .flush  (FlushE),
        .busy   (mdBusy),
        .done   (mdDone),
        .result (mdResult)
      );
    end else begin : g_nomd
      assign mdBusy   = 1'b0;
      assign mdDone   = 1'b0;
      assign mdResult = '0;
    end
  endgenerate

  assign BusyE = mdBusy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RDM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
    end else if (BusyE || FlushE) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RDM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
    end else begin
      ALUResultM <= mdDone ? mdResult : aluRes;
      WriteDataM <= srcBF;
      PCPlus4M   <= PCPlus4E;
      RDM        <= RDE;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
    end
  end

endmodule

// File: tb/tb_execute_stage_m.sv
// Directed bench for execute_stage_m: ALU/forwarding, branches, M ops with
// busy timing, flush abort, async reset mid-op, and an XLEN=64 instance.
module tb_execute_stage_m;
  import exec_pkg::*;

  logic        clk = 0, rst;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MulDivE, FlushE;
  logic [1:0]  ResultSrcE, Forward_AE, Forward_BE;
  logic [3:0]  ALUControlE;
  logic [2:0]  BranchTypeE, MulDivOpE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
  logic [4:0]  RDE;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic        PCSrcE, BusyE, RegWriteM, MemWriteM;
  logic [4:0]  RDM;
  logic [1:0]  ResultSrcM;

  logic        md64;
  logic [63:0] a64, b64, tgt64, res64, wd64, p4m64;
  logic        pcs64, busy64, rw64, mw64;
  logic [4:0]  rdm64;
  logic [1:0]  rsm64;

  int nChk = 0, nPass = 0;

  always #5 clk = ~clk;

  execute_stage_m #(.XLEN(32), .REG_AW(5), .MULDIV_EN(1)) dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .ALUSrcE(ALUSrcE),
    .MulDivE(MulDivE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .BranchTypeE(BranchTypeE), .MulDivOpE(MulDivOpE), .RD1E(RD1E), .RD2E(RD2E),
    .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RDE(RDE),
    .ResultW(ResultW), .Forward_AE(Forward_AE), .Forward_BE(Forward_BE),
    .FlushE(FlushE), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .BusyE(BusyE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RDM(RDM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
  );

  execute_stage_m #(.XLEN(64), .REG_AW(5), .MULDIV_EN(1)) dut64 (
    .clk(clk), .rst(rst), .RegWriteE(1'b1), .MemWriteE(1'b0),
    .BranchE(1'b0), .JumpE(1'b0), .JalrE(1'b0), .ALUSrcE(1'b0),
    .MulDivE(md64), .ResultSrcE(2'b00), .ALUControlE(ALU_ADD),
    .BranchTypeE(3'b000), .MulDivOpE(MD_MUL), .RD1E(a64), .RD2E(b64),
    .PCE(64'd0), .ImmExtE(64'd0), .PCPlus4E(64'd0), .RDE(5'd1),
    .ResultW(64'd0), .Forward_AE(2'b00), .Forward_BE(2'b00),
    .FlushE(1'b0), .PCTargetE(tgt64), .PCSrcE(pcs64), .BusyE(busy64),
    .ALUResultM(res64), .WriteDataM(wd64), .PCPlus4M(p4m64),
    .RDM(rdm64), .RegWriteM(rw64), .MemWriteM(mw64), .ResultSrcM(rsm64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick;
    @(negedge clk); #1;
  endtask

  task automatic clrIn;
    RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0; JalrE = 0;
    ALUSrcE = 0; MulDivE = 0; FlushE = 0; ResultSrcE = 0;
    Forward_AE = FWD_RF; Forward_BE = FWD_RF; ALUControlE = ALU_ADD;
    BranchTypeE = 0; MulDivOpE = 0; RD1E = 0; RD2E = 0; PCE = 0;
    ImmExtE = 0; PCPlus4E = 0; ResultW = 0; RDE = 0;
  endtask

  // One-cycle ALU op: drive, step one edge, compare the M-stage result.
  task automatic aluOp(input string tag, input logic [3:0] ctl,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    clrIn;
    ALUControlE = ctl; RD1E = a; RD2E = b; RegWriteE = 1; RDE = 5'd2;
    tick;
    chk(tag, ALUResultM, exp);
  endtask

  // M op held in E until BusyE drops; expects XLEN+1 busy cycles and bubbles.
  task automatic mdOp(input string tag, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int  n;
    logic bub;
    clrIn;
    MulDivE = 1; MulDivOpE = op; RD1E = a; RD2E = b; RegWriteE = 1; RDE = 5'd7;
    #1;
    n = 0; bub = 1;
    while (BusyE === 1'b1 && n < 200) begin
      if (n > 0 && (RegWriteM !== 1'b0 || ALUResultM !== '0)) bub = 0;
      n++;
      tick;
    end
    chk({tag, "_busy"}, 64'(n), 64'd33);
    chk({tag, "_bubble"}, {63'd0, bub}, 64'd1);
    MulDivE = 0;
    tick;
    chk(tag, ALUResultM, exp);
    chk({tag, "_rd"}, {59'd0, RDM}, 64'd7);
    clrIn;
  endtask

  initial begin
    int  n;
    logic ok;
    clrIn;
    md64 = 0; a64 = 0; b64 = 0;
    rst = 1;
    tick; tick;
    chk("rst_alu", ALUResultM, 0);
    chk("rst_rw", {63'd0, RegWriteM}, 0);
    chk("rst_busy", {63'd0, BusyE}, 0);
    chk("rst_pcsrc", {63'd0, PCSrcE}, 0);
    chk("rst_res64", res64, 0);
    rst = 0;

    // Forwarding from M: 2+3 -> 5, then ALUResultM(5) + imm 7 -> 12.
    clrIn;
    RD1E = 2; ImmExtE = 3; ALUSrcE = 1; RegWriteE = 1; RDE = 5'd3;
    tick;
    chk("add_first", ALUResultM, 5);
    chk("add_rd", {59'd0, RDM}, 3);
    Forward_AE = FWD_MEM; RD1E = 99; ImmExtE = 7;
    #1 chk("add_fwd_busy", {63'd0, BusyE}, 0);
    tick;
    chk("add_fwd", ALUResultM, 12);

    aluOp("sub", ALU_SUB, 3, 5, 32'hFFFF_FFFE);
    aluOp("slt", ALU_SLT, 32'hFFFF_FFFF, 1, 1);
    aluOp("sltu", ALU_SLTU, 32'hFFFF_FFFF, 1, 0);
    aluOp("sra", ALU_SRA, 32'h8000_0000, 4, 32'hF800_0000);
    aluOp("srl", ALU_SRL, 32'h8000_0000, 4, 32'h0800_0000);
    aluOp("sll_mask", ALU_SLL, 1, 33, 2);
    aluOp("xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    aluOp("op12", 4'd12, 32'h1234, 32'h5678, 0);

    // Forwarding from W on B, store data follows forwarded rs2.
    clrIn;
    ALUControlE = ALU_OR; RD1E = 1; RD2E = 32'hDEAD; Forward_BE = FWD_WB;
    ResultW = 32'h10; MemWriteE = 1; PCPlus4E = 32'h44;
    tick;
    chk("or_fwdw", ALUResultM, 32'h11);
    chk("wdata_fwdw", WriteDataM, 32'h10);
    chk("memw", {63'd0, MemWriteM}, 1);
    chk("pc4m", PCPlus4M, 32'h44);

    // Branches and jumps (combinational).
    clrIn;
    BranchE = 1; BranchTypeE = BR_BLTU; RD1E = 1; RD2E = 32'hFFFF_FFFF;
    PCE = 32'h100; ImmExtE = 32'h20;
    #1;
    chk("bltu_src", {63'd0, PCSrcE}, 1);
    chk("bltu_tgt", PCTargetE, 32'h120);
    BranchTypeE = BR_BLT;
    #1 chk("blt_src", {63'd0, PCSrcE}, 0);
    BranchTypeE = BR_BGE;
    #1 chk("bge_src", {63'd0, PCSrcE}, 1);
    BranchTypeE = 3'b010;
    #1 chk("br_undef", {63'd0, PCSrcE}, 0);
    clrIn;
    JumpE = 1; JalrE = 1; RD1E = 32'h1001; ImmExtE = 32'h10; PCE = 32'h500;
    #1;
    chk("jalr_tgt", PCTargetE, 32'h1010);
    chk("jalr_src", {63'd0, PCSrcE}, 1);
    FlushE = 1;
    #1 chk("jalr_flush", {63'd0, PCSrcE}, 0);
    clrIn;
    tick;

    // Multiply/divide unit.
    mdOp("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    mdOp("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    mdOp("rem_z", MD_REM, 7, 0, 7);
    mdOp("divu_z", MD_DIVU, 7, 0, 32'hFFFF_FFFF);
    mdOp("mul", MD_MUL, 7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    mdOp("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mdOp("div", MD_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
    mdOp("rem", MD_REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
    mdOp("remu", MD_REMU, 100, 7, 2);

    // Flush at RUN cycle 10 of a DIV, then a normal ADD.
    clrIn;
    MulDivE = 1; MulDivOpE = MD_DIV; RD1E = 100; RD2E = 7; RegWriteE = 1; RDE = 5'd9;
    tick;
    repeat (9) tick;
    FlushE = 1;
    #1 chk("flush_run_busy", {63'd0, BusyE}, 1);
    tick;
    clrIn;
    RD1E = 40; RD2E = 2; RegWriteE = 1; RDE = 5'd4;
    #1;
    chk("flush_busy_drop", {63'd0, BusyE}, 0);
    chk("flush_bubble", {63'd0, RegWriteM}, 0);
    tick;
    chk("post_flush_add", ALUResultM, 42);
    chk("post_flush_rw", {63'd0, RegWriteM}, 1);

    // Async reset clears a populated EX/MEM register without a clock edge.
    rst = 1;
    #1;
    chk("arst_alu", ALUResultM, 0);
    chk("arst_rw", {63'd0, RegWriteM}, 0);
    tick;
    rst = 0;

    // Reset at RUN cycle 5: unit drops to IDLE and never delivers.
    clrIn;
    MulDivE = 1; MulDivOpE = MD_MUL; RD1E = 6; RD2E = 7; RegWriteE = 1; RDE = 5'd9;
    tick;
    repeat (4) tick;
    chk("rst_mid_busy_before", {63'd0, BusyE}, 1);
    rst = 1; clrIn;
    #1;
    chk("rst_mid_busy", {63'd0, BusyE}, 0);
    chk("rst_mid_alu", ALUResultM, 0);
    chk("rst_mid_rdm", {59'd0, RDM}, 0);
    tick;
    rst = 0;
    ok = 1;
    for (int i = 0; i < 40; i++) begin
      if (BusyE !== 1'b0 || ALUResultM !== '0) ok = 0;
      tick;
    end
    chk("rst_mid_no_result", {63'd0, ok}, 1);
    mdOp("mul_after_rst", MD_MUL, 6, 7, 42);

    // XLEN=64 instance: MUL 3 * -5, busy 65 cycles.
    md64 = 1; a64 = 64'd3; b64 = 64'hFFFF_FFFF_FFFF_FFFB;
    #1;
    n = 0;
    while (busy64 === 1'b1 && n < 300) begin
      n++;
      tick;
    end
    chk("x64_busy", 64'(n), 64'd65);
    md64 = 0;
    tick;
    chk("x64_mul", res64, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("x64_rw", {63'd0, rw64}, 1);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/execute_stage_m.md
# execute_stage_m

Parametrised successor to the 5-stage RISC-V execute stage.
- Combinational part: forwarding, an extended ALU, full RV32 branch resolution and JALR targets, computed in one cycle.
- Multi-cycle part: an iterative multiply/divide unit (M extension) that stalls the front of the pipeline through a busy handshake.
- Owns the EX/MEM pipeline register.
- Sits between the ID/EX register and the memory stage; forwarding selects come from the hazard unit.

## Interface
Parameters
- XLEN, 32, datapath width; power of two, ≥8.
- REG_AW, 5, register-address width.
- MULDIV_EN, 1, 0 removes the multiply/divide unit; MulDivE is then ignored.

Ports
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MulDivE  in  1 each  decoded E-stage controls.
- ResultSrcE  in  2  writeback source.
- ALUControlE  in  4  ALU op.
- BranchTypeE  in  3  funct3 branch condition.
- MulDivOpE  in  3  funct3 M op.
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  XLEN  operands.
- RDE  in  REG_AW  destination register.
- ResultW  in  XLEN  writeback-stage forward value.
- Forward_AE, Forward_BE  in  2  forward select: 00 regfile, 01 ResultW, 10 ALUResultM.
- FlushE  in  1  kill the E-stage instruction.
- PCTargetE  out  XLEN  branch/jump target.
- PCSrcE  out  1  redirect fetch.
- BusyE  out  1  stall request to hazard unit: hold F/D/E.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  EX/MEM register.
- RDM  out  REG_AW  EX/MEM register.
- RegWriteM, MemWriteM  out  1  EX/MEM register.
- ResultSrcM  out  2  EX/MEM register.

## Operation
- SrcA is the forwarded RD1E. SrcB_fwd is the forwarded RD2E. SrcB is ImmExtE when ALUSrcE=1, else SrcB_fwd. WriteDataM is captured from SrcB_fwd.
- ALU ops: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9. Shift amount is SrcB[log2 XLEN-1:0]. Codes 10–15 give 0.
- Branch conditions on SrcA/SrcB_fwd: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111; other codes are not taken.
- PCSrcE = (BranchE & cond) | JumpE, forced 0 while FlushE=1.
- PCTargetE = JalrE ? ((SrcA+ImmExtE) & ~1) : PCE+ImmExtE. All sums wrap modulo 2^XLEN.
- M ops: MUL 0, MULH 1, MULHSU 2, MULHU 3, DIV 4, DIVU 5, REM 6, REMU 7.
  - Multiply: shift-add on a 2·XLEN product.
  - Divide: restoring, one bit per cycle, on magnitudes with sign fix-up.
- Divide by zero: quotient all ones; remainder = dividend.
- Signed overflow (−2^(XLEN−1) ÷ −1): quotient = dividend; remainder 0.
- FSM, iteration counter width clog2(XLEN)+1:
  - IDLE→RUN when MulDivE & MULDIV_EN & ~FlushE. Forwarded operands and the op are latched; the counter loads XLEN.
  - RUN: one iteration per cycle, counter decrements. RUN→DONE when the counter reaches 1 on that edge.
  - DONE→IDLE unconditionally. No restart from DONE, even though MulDivE is still high.
- BusyE = (IDLE & MulDivE & MULDIV_EN & ~FlushE) | RUN. Combinational.
- EX/MEM load:
  - BusyE=1 or FlushE=1: load a bubble (RegWrite 0, MemWrite 0, RDM 0, data 0).
  - DONE: load the M result with the E-stage controls.
  - Otherwise: load the ALU result.
- FlushE in RUN or DONE aborts the operation: FSM→IDLE, bubble loaded.
- Reset mid-operation: FSM→IDLE immediately; no result is produced.

## Timing
- ALU ops: one cycle; result visible on ALUResultM one edge after the instruction is in E.
- PCSrcE/PCTargetE: combinational in the same cycle.
- M ops:
  - Accept cycle 0.
  - RUN cycles 1..XLEN.
  - DONE cycle XLEN+1.
  - BusyE high for cycles 0..XLEN (XLEN+1 cycles).
  - Result on ALUResultM after the edge ending cycle XLEN+1; E occupancy is XLEN+2 cycles.
- Back-to-back M ops: the second is accepted the cycle after DONE.
- Reset values: every M-side output is 0; BusyE 0, PCSrcE 0, FSM IDLE, counter 0.

## Structure
- Package exec_pkg holds:
  - ALU op constants.
  - Branch-type constants.
  - M-op constants.
  - FSM state enum (IDLE, RUN, DONE).
  - Forward-select constants.
- Sub-module muldiv_iter holds the FSM, counter, operand latches and result fix-up. Its ports: start, op, a, b, flush, busy, done, result.

## Test plan
- ADD with Forward_AE=10, ALUResultM=5, RD1E=99, ImmExtE=7, ALUSrcE=1 → ALUResultM=12 next edge; BusyE=0.
- BLTU with SrcA=1, SrcB=0xFFFFFFFF, PCE=0x100, ImmExtE=0x20 → PCSrcE=1, PCTargetE=0x120. Same operands with BLT → PCSrcE=0.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → BusyE high exactly 33 cycles, bubbles in M meanwhile, then ALUResultM=0xFFFFFFFE.
- DIV 0x80000000÷0xFFFFFFFF → 0x80000000. REM 7÷0 → 7. DIVU 7÷0 → 0xFFFFFFFF.
- FlushE at RUN cycle 10 of DIV → BusyE drops next cycle, RegWriteM stays 0, next ADD completes normally.
- rst pulsed at RUN cycle 5 → all outputs 0 immediately, FSM IDLE. XLEN=64 rerun of the MUL case → BusyE high 65 cycles.
